// File: rtl/debounce_pkg.sv
// Shared types and limits for the debounce_sync input conditioning stage.
package debounce_pkg;

   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      PEND_HI   = 2'd1,
      STABLE_HI = 2'd2,
      PEND_LO   = 2'd3
   } deb_state_t;

   localparam int MIN_STABLE_CYCLES = 2;
   localparam int MAX_SYNC_STAGES   = 4;

endpackage : debounce_pkg

// File: rtl/debounce_sync_sync_chain.sv
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
module sync_chain #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], din};
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign dout = sync_q[SYNC_STAGES-1];

endmodule : sync_chain

// File: rtl/debounce_sync.sv
// Synchronizer plus counter-validated debounce FSM with registered level and edge pulses.
// Optional accepted-transition counter enabled by defining DEBOUNCE_EVENT_CNT_EN.
module debounce_sync
   import debounce_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       raw_in,
   output logic       d_clean,
   output logic       rise_pulse,
   output logic       fall_pulse,
   output logic       busy,
   output logic [7:0] event_cnt
);

   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic             s;
   deb_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             d_clean_q, d_clean_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic             busy_q, busy_d;

   sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (raw_in),
      .dout (s)
   );

   // NOTE: every variable gets a default before the case so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      d_clean_d = d_clean_q;
      rise_d    = 1'b0;
      fall_d    = 1'b0;
      case (state_q)
         STABLE_LO: begin
            d_clean_d = 1'b0;
            if (s) begin
               state_d = PEND_HI;
               cnt_d   = CNT_W'(1);
            end else begin
               cnt_d = '0;
            end
         end
         PEND_HI: begin
            if (!s) begin
               state_d = STABLE_LO;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = STABLE_HI;
               d_clean_d = 1'b1;
               rise_d    = 1'b1;
               cnt_d     = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         STABLE_HI: begin
            d_clean_d = 1'b1;
            if (!s) begin
               state_d = PEND_LO;
               cnt_d   = CNT_W'(1);
            end else begin
               cnt_d = '0;
            end
         end
         PEND_LO: begin
            if (s) begin
               state_d = STABLE_HI;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = STABLE_LO;
               d_clean_d = 1'b0;
               fall_d    = 1'b1;
               cnt_d     = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = STABLE_LO;
            cnt_d   = '0;
         end
      endcase
      busy_d = (state_d == PEND_HI) || (state_d == PEND_LO);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= STABLE_LO;
         cnt_q     <= '0;
         d_clean_q <= 1'b0;
         rise_q    <= 1'b0;
         fall_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         d_clean_q <= d_clean_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
         busy_q    <= busy_d;
      end
   end

`ifdef DEBOUNCE_EVENT_CNT_EN
   logic [7:0] event_cnt_q, event_cnt_d;

   // Counts on the same edge that raises a pulse, wrapping naturally at 8 bits.
   always_comb begin
      event_cnt_d = event_cnt_q + {7'd0, rise_d | fall_d};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         event_cnt_q <= 8'd0;
      end else begin
         event_cnt_q <= event_cnt_d;
      end
   end

   assign event_cnt = event_cnt_q;
`else
   assign event_cnt = 8'd0;
`endif

   assign d_clean    = d_clean_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;
   assign busy       = busy_q;

endmodule : debounce_sync
